// File: rtl/bus_arbiter.sv
// Three-requester round-robin bus arbiter with a bounded tenure.
// Each grant latches the winner's A/B source codes and drives them onto the bus enables.
module bus_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [2:0] a_sel0,
  input  logic [2:0] a_sel1,
  input  logic [2:0] a_sel2,
  input  logic [2:0] b_sel0,
  input  logic [2:0] b_sel1,
  input  logic [2:0] b_sel2,
  output logic [2:0] gnt,
  output logic [2:0] abus_en,
  output logic [2:0] bbus_en,
  output logic       busy,
  output logic       sel_err,
  output logic [1:0] state_o
);

  // Handshake: req[i] is a level request; requester i owns the bus exactly
  // while gnt[i]=1. Dropping req[i] ends the tenure at the next edge; no
  // other requester can take the bus until the TURN/IDLE gap has elapsed.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] g_q, g_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] gnt_q, gnt_d;
  logic [2:0] abus_q, abus_d;
  logic [2:0] bbus_q, bbus_d;
  logic       sel_err_q, sel_err_d;

  logic [1:0] win;
  logic [2:0] idx;
  logic       found;
  logic [2:0] a_raw, b_raw, a_fix, b_fix;
  logic       a_bad, b_bad;
  logic       owner_req;

  // First set request at or above ptr, wrapping modulo 3.
  always_comb begin
    win   = 2'd0;
    found = 1'b0;
    idx   = 3'd0;
    for (int k = 0; k < 3; k++) begin
      idx = {1'b0, ptr_q} + 3'(k);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (!found && req[idx[1:0]]) begin
        found = 1'b1;
        win   = idx[1:0];
      end
    end
  end

  always_comb begin
    a_raw = a_sel0;
    b_raw = b_sel0;
    case (win)
      2'd1:    begin a_raw = a_sel1; b_raw = b_sel1; end
      2'd2:    begin a_raw = a_sel2; b_raw = b_sel2; end
      default: begin a_raw = a_sel0; b_raw = b_sel0; end
    endcase
  end

  // A code 5 and B codes 1-3 name no legal source on that bus.
  assign a_bad = (a_raw == 3'd5);
  assign b_bad = (b_raw == 3'd1) || (b_raw == 3'd2) || (b_raw == 3'd3);
  assign a_fix = a_bad ? 3'd0 : a_raw;
  assign b_fix = b_bad ? 3'd0 : b_raw;

  assign owner_req = |(req & gnt_q);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    g_d       = g_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    abus_d    = abus_q;
    bbus_d    = bbus_q;
    sel_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d  = 3'd0;
        abus_d = 3'd0;
        bbus_d = 3'd0;
        cnt_d  = 8'd0;
        if (|req) begin
          state_d   = GRANT;
          g_d       = win;
          gnt_d     = 3'b001 << win;
          abus_d    = a_fix;
          bbus_d    = b_fix;
          sel_err_d = a_bad | b_bad;
        end
      end
      GRANT: begin
        cnt_d = cnt_q + 8'd1;
        if (!owner_req || (cnt_q == CNT_LAST)) begin
          state_d = TURN;
          gnt_d   = 3'd0;
          abus_d  = 3'd0;
          bbus_d  = 3'd0;
          ptr_d   = (g_q == 2'd2) ? 2'd0 : g_q + 2'd1;
        end
      end
      TURN: begin
        state_d = IDLE;
        gnt_d   = 3'd0;
        abus_d  = 3'd0;
        bbus_d  = 3'd0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 3'd0;
        abus_d  = 3'd0;
        bbus_d  = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      g_q       <= 2'd0;
      cnt_q     <= 8'd0;
      gnt_q     <= 3'd0;
      abus_q    <= 3'd0;
      bbus_q    <= 3'd0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      g_q       <= g_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      abus_q    <= abus_d;
      bbus_q    <= bbus_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign gnt     = gnt_q;
  assign abus_en = abus_q;
  assign bbus_en = bbus_q;
  assign sel_err = sel_err_q;
  assign busy    = (state_q != IDLE);
  assign state_o = state_q;

endmodule
